// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - shared opcode, state and width definitions (package proc_defs)
package proc_defs;

    localparam int IW  = 9;
    localparam int PCW = 8;
    localparam int CW  = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NAN = 3'b010,
        OP_ILL = 3'b011,
        OP_OUT = 3'b100,
        OP_LDI = 3'b101,
        OP_HLT = 3'b110,
        OP_REP = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } seq_state_t;

    function automatic opcode_t opcode_of(input logic [IW-1:0] word);
        return opcode_t'(word[IW-1:IW-3]);
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - instruction word handshake between fetch source and sequencer
interface instruction_sequencer_if
    import proc_defs::*;
    ();

    logic          ir_valid;
    logic [IW-1:0] ir_data;
    logic          ir_ready;

    modport master (
        output ir_valid,
        output ir_data,
        input  ir_ready
    );

    modport slave (
        input  ir_valid,
        input  ir_data,
        output ir_ready
    );

endinterface

// File: rtl/seq_step_counter.sv
// rtl/seq_step_counter.sv - 2-bit execution step counter with clear, enable and terminal flag
module seq_step_counter
    import proc_defs::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] step,
    output logic          terminal
);

    // clear wins over enable so the counter always leaves EXEC at zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step <= '0;
        end else if (clear) begin
            step <= '0;
        end else if (enable) begin
            step <= step + 1'b1;
        end
    end

    assign terminal = (step == {CW{1'b1}});

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer: latches instructions, steps cont 00..11, halts on HLT
module instruction_sequencer
    import proc_defs::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    run,
    instruction_sequencer_if.slave  ir,
    output logic [PCW-1:0]          pc,
    output logic [IW-1:0]           instr,
    output logic [CW-1:0]           cont,
    output logic                    busy,
    output logic                    done,
    output logic                    halted,
    output logic                    illegal
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       ir_ready_q;
    logic       accept;
    opcode_t    op;
    logic       step_clear;
    logic       step_enable;
    logic       step_term;

    assign ir.ir_ready = ir_ready_q;
    assign op          = opcode_of(ir.ir_data);
    assign accept      = (state == ST_FETCH) && ir.ir_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (accept) begin
                    if (op == OP_HLT)      state_nxt = ST_HALTED;
                    else if (op == OP_ILL) state_nxt = run ? ST_FETCH : ST_IDLE;
                    else                   state_nxt = ST_EXEC;
                end else begin
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_EXEC: begin
                // run is only sampled after the last step so an instruction is never cut short
                if (step_term) state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign step_enable = (state == ST_EXEC);
    assign step_clear  = (state != ST_EXEC) || step_term;

    seq_step_counter u_step (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (step_clear),
        .enable   (step_enable),
        .step     (cont),
        .terminal (step_term)
    );

    // status flags are registered from the next state so they align with the state they describe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            pc         <= '0;
            instr      <= '0;
            ir_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ir_ready_q <= (state_nxt == ST_FETCH);
            busy       <= (state_nxt == ST_EXEC);
            halted     <= (state_nxt == ST_HALTED);
            done       <= (state == ST_EXEC) && (cont == 2'b10);
            illegal    <= accept && (op == OP_ILL);
            if (accept) begin
                instr <= ir.ir_data;
                pc    <= pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - randomized self-checking bench with cycle-level reference model
module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       run = 1'b0;
    logic [7:0] pc;
    logic [8:0] instr;
    logic [1:0] cont;
    logic       busy, done, halted, illegal;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int ill_cnt  = 0;

    // reference model: mode 0 idle, 1 fetch, 2 exec, 3 halted
    int         m_mode = 0;
    int         m_step = 0;
    logic [7:0] m_pc = '0;
    logic [8:0] m_instr = '0;
    bit         m_ill = 1'b0;

    always #5 clk = ~clk;

    instruction_sequencer_if ir_bus ();

    instruction_sequencer dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .ir      (ir_bus),
        .pc      (pc),
        .instr   (instr),
        .cont    (cont),
        .busy    (busy),
        .done    (done),
        .halted  (halted),
        .illegal (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_mode = 0; m_step = 0; m_pc = '0; m_instr = '0; m_ill = 1'b0;
            end
            check("ir_ready", {31'd0, ir_bus.ir_ready}, {31'd0, m_mode == 1});
            check("busy",     {31'd0, busy},    {31'd0, m_mode == 2});
            check("halted",   {31'd0, halted},  {31'd0, m_mode == 3});
            check("done",     {31'd0, done},    {31'd0, (m_mode == 2) && (m_step == 3)});
            check("cont",     {30'd0, cont},    (m_mode == 2) ? m_step : 0);
            check("illegal",  {31'd0, illegal}, {31'd0, m_ill});
            check("pc",       {24'd0, pc},      {24'd0, m_pc});
            check("instr",    {23'd0, instr},   {23'd0, m_instr});
            if (done)    done_cnt++;
            if (illegal) ill_cnt++;
            if (resetn) begin
                m_ill = 1'b0;
                case (m_mode)
                    0: if (run) m_mode = 1;
                    1: begin
                        if (ir_bus.ir_valid) begin
                            m_instr = ir_bus.ir_data;
                            m_pc    = m_pc + 8'd1;
                            if (ir_bus.ir_data[8:6] == 3'b110) m_mode = 3;
                            else if (ir_bus.ir_data[8:6] == 3'b011) begin
                                m_ill  = 1'b1;
                                m_mode = run ? 1 : 0;
                            end else begin
                                m_mode = 2;
                                m_step = 0;
                            end
                        end else begin
                            m_mode = run ? 1 : 0;
                        end
                    end
                    2: begin
                        if (m_step == 3) m_mode = run ? 1 : 0;
                        else m_step = m_step + 1;
                    end
                    default: m_mode = 3;
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1);
        resetn = 1'b0;
        run = 1'b0;
        ir_bus.ir_valid = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    task automatic wait_cont(input logic [1:0] v, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            tick(1);
            if (cont == v) break;
        end
        if (k == budget) check("wait_cont_timeout", 32'd1, 32'd0);
    endtask

    logic [8:0] words [3];
    int d0, i0;

    initial begin
        ir_bus.ir_valid = 1'b0;
        ir_bus.ir_data  = '0;
        tick(2);
        check("reset_pc", {24'd0, pc}, 32'd0);
        check("reset_ready", {31'd0, ir_bus.ir_ready}, 32'd0);
        resetn = 1'b1;

        // single instruction, accepted at first FETCH edge
        do_reset();
        d0 = done_cnt;
        run = 1'b1; ir_bus.ir_valid = 1'b1; ir_bus.ir_data = 9'b000_001_010;
        tick(2);
        ir_bus.ir_valid = 1'b0;
        check("t1_cont0", {30'd0, cont}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_instr", {23'd0, instr}, 32'h00a);
        tick(3);
        check("t1_cont3", {30'd0, cont}, 32'd3);
        check("t1_done", {31'd0, done}, 32'd1);
        run = 1'b0;
        tick(3);
        check("t1_pc", {24'd0, pc}, 32'd1);
        check("t1_done_count", done_cnt - d0, 32'd1);

        // back-to-back words
        do_reset();
        words[0] = 9'b001_000_011; words[1] = 9'b101_010_000; words[2] = 9'b010_011_100;
        run = 1'b1; ir_bus.ir_valid = 1'b1; ir_bus.ir_data = words[0];
        for (int idx = 0, b = 0; idx < 3 && b < 60; b++) begin
            bit acc;
            @(negedge clk);
            acc = ir_bus.ir_ready && ir_bus.ir_valid;
            tick(1);
            if (acc) begin
                idx++;
                if (idx < 3) ir_bus.ir_data = words[idx];
            end
        end
        ir_bus.ir_valid = 1'b0;
        run = 1'b0;
        tick(6);
        check("t2_pc", {24'd0, pc}, 32'd3);
        check("t2_instr", {23'd0, instr}, {23'd0, words[2]});

        // drop run at cont=01
        do_reset();
        d0 = done_cnt;
        run = 1'b1; ir_bus.ir_valid = 1'b1; ir_bus.ir_data = 9'b100_111_001;
        wait_cont(2'b01, 20);
        run = 1'b0; ir_bus.ir_valid = 1'b0;
        tick(8);
        check("t3_done_count", done_cnt - d0, 32'd1);
        check("t3_ready", {31'd0, ir_bus.ir_ready}, 32'd0);

        // illegal then halt
        do_reset();
        i0 = ill_cnt;
        run = 1'b1; ir_bus.ir_valid = 1'b1; ir_bus.ir_data = 9'b011_000_000;
        tick(2);
        ir_bus.ir_data = 9'b110_000_000;
        tick(22);
        check("t4_illegal_count", ill_cnt - i0, 32'd1);
        check("t4_halted", {31'd0, halted}, 32'd1);
        check("t4_ready", {31'd0, ir_bus.ir_ready}, 32'd0);
        check("t4_cont", {30'd0, cont}, 32'd0);
        check("t4_pc", {24'd0, pc}, 32'd2);

        // pc wrap, then asynchronous reset mid-EXEC
        do_reset();
        run = 1'b1; ir_bus.ir_valid = 1'b1; ir_bus.ir_data = 9'b011_001_001;
        for (int b = 0; b < 400 && pc != 8'd255; b++) tick(1);
        ir_bus.ir_data = 9'b000_101_110;
        wait_cont(2'b10, 10);
        check("t5_pc_wrap", {24'd0, pc}, 32'd0);
        d0 = done_cnt;
        #1 resetn = 1'b0;
        #1;
        check("t5_async_cont", {30'd0, cont}, 32'd0);
        check("t5_async_instr", {23'd0, instr}, 32'd0);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        check("t5_async_ready", {31'd0, ir_bus.ir_ready}, 32'd0);
        ir_bus.ir_valid = 1'b0;
        tick(2);
        resetn = 1'b1;
        run = 1'b0;
        tick(4);
        check("t5_no_done", done_cnt - d0, 32'd0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            if (!resetn) resetn = 1'b1;
            else if ($urandom_range(99) == 0) resetn = 1'b0;
            run = ($urandom_range(7) != 0);
            ir_bus.ir_valid = $urandom_range(1);
            ir_bus.ir_data = 9'($urandom);
            if (ir_bus.ir_data[8:6] == 3'b110 && $urandom_range(9) != 0) ir_bus.ir_data[8:6] = 3'b000;
        end
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
